// File: rtl/booth_seq_multiplier.sv
// booth_seq_multiplier: sequential signed multiplier using radix-2 Booth
// recoding, one step per clock. A two-process control FSM (IDLE/LOAD/CALC/DONE)
// sequences an iteration counter and the {U,Q,q_1} shift datapath.
// Optional debug taps: define BOOTH_DEBUG_EN to add dbg_state/dbg_count ports
// and a simulation trace of every state transition.
module booth_seq_multiplier #(
    parameter int WIDTH = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   ab_result,
    output logic                 busy,
    output logic                 done
`ifdef BOOTH_DEBUG_EN
    ,
    output logic [1:0]           dbg_state,
    output logic [$clog2(WIDTH):0] dbg_count
`endif
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CALC = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                state_r, state_nx_s;
    logic                  load_s, step_s, finish_s, init_count_s, cnt_ge_max_s;
    logic [CW-1:0]         count_r;
    logic [WIDTH-1:0]      a_r;
    logic [WIDTH:0]        u_r, u_nx_s;
    logic [WIDTH-1:0]      q_r, q_nx_s;
    logic                  q1_r, q1_nx_s;
    logic [2*WIDTH-1:0]    ab_result_r;
    logic                  busy_r, done_r;

    // One Booth step: add/subtract the sign-extended multiplicand according to
    // {Q[0], q_1}, then arithmetic shift of {U,Q,q_1} right by one bit.
    // U carries one extra bit so negating -2^(WIDTH-1) cannot overflow.
    function automatic logic [2*WIDTH+1:0] booth_step(
        input logic [WIDTH:0]   u,
        input logic [WIDTH-1:0] q,
        input logic             q1,
        input logic [WIDTH-1:0] m
    );
        logic [WIDTH:0] m_ext;
        logic [WIDTH:0] sum;
        m_ext = {m[WIDTH-1], m};
        case ({q[0], q1})
            2'b01:   sum = u + m_ext;
            2'b10:   sum = u - m_ext;
            default: sum = u;
        endcase
        return {sum[WIDTH], sum[WIDTH:1], sum[0], q[WIDTH-1:1], q[0]};
    endfunction

    assign cnt_ge_max_s = (count_r >= CNT_MAX);

    // Combinational Booth step on the current datapath registers.
    always_comb begin
        {u_nx_s, q_nx_s, q1_nx_s} = booth_step(u_r, q_r, q1_r, a_r);
    end

    // Control FSM: next state and datapath/counter strobes.
    always_comb begin
        state_nx_s   = state_r;
        load_s       = 1'b0;
        step_s       = 1'b0;
        finish_s     = 1'b0;
        init_count_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nx_s = LOAD;
                    load_s     = 1'b1;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            LOAD: state_nx_s = CALC;
            CALC: begin
                step_s       = 1'b1;
                init_count_s = 1'b1;
                if (cnt_ge_max_s) begin
                    state_nx_s = DONE;
                    finish_s   = 1'b1;
                end else begin
                    state_nx_s = CALC;
                end
            end
            DONE:    state_nx_s = IDLE;
            default: state_nx_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Iteration counter: counts only in CALC, held cleared everywhere else.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_r <= {CW{1'b0}};
        end else if (init_count_s) begin
            count_r <= count_r + CW'(1);
        end else begin
            count_r <= {CW{1'b0}};
        end
    end

    // Datapath: operands captured on the start edge, then one Booth step per CALC cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            a_r  <= {WIDTH{1'b0}};
            u_r  <= {(WIDTH+1){1'b0}};
            q_r  <= {WIDTH{1'b0}};
            q1_r <= 1'b0;
        end else if (load_s) begin
            a_r  <= a;
            u_r  <= {(WIDTH+1){1'b0}};
            q_r  <= b;
            q1_r <= 1'b0;
        end else if (step_s) begin
            u_r  <= u_nx_s;
            q_r  <= q_nx_s;
            q1_r <= q1_nx_s;
        end
    end

    // Registered outputs: result latched on the final step, done pulses in DONE.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ab_result_r <= {(2*WIDTH){1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            if (finish_s) begin
                ab_result_r <= {u_nx_s[WIDTH-1:0], q_nx_s};
            end
            busy_r <= (state_nx_s != IDLE);
            done_r <= finish_s;
        end
    end

    assign ab_result = ab_result_r;
    assign busy      = busy_r;
    assign done      = done_r;

`ifdef BOOTH_DEBUG_EN
    assign dbg_state = state_r;
    assign dbg_count = count_r;

    // Simulation trace of every state transition.
    always @(posedge clock) begin
        if (!reset && (state_nx_s != state_r)) begin
            $display("[booth_seq_multiplier] %0t: state %0d -> %0d", $time, state_r, state_nx_s);
        end
    end
`else
    // No debug taps in this build.
`endif

endmodule

// File: tb/tb_booth_seq_multiplier.sv
// tb_booth_seq_multiplier: randomized and directed self-checking bench for
// booth_seq_multiplier (WIDTH=4). Expected products come from plain integer
// multiplication of the two signed operands.
module tb_booth_seq_multiplier;

    localparam int W = 4;

    logic           clock = 1'b0;
    logic           reset;
    logic           start;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] ab_result;
    logic           busy;
    logic           done;

    int tests_run = 0;
    int tests_failed = 0;

    booth_seq_multiplier #(.WIDTH(W)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .a         (a),
        .b         (b),
        .ab_result (ab_result),
        .busy      (busy),
        .done      (done)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input int obs, input int exp);
        tests_run++;
        if (obs != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int result_s();
        return int'($signed(ab_result));
    endfunction

    // Reference product: plain signed integer multiply, truncated to 2*W bits
    // (always exact for W-bit signed operands).
    function automatic int ref_product(input int x, input int y);
        int p;
        logic [2*W-1:0] t;
        p = x * y;
        t = p[2*W-1:0];
        return int'($signed(t));
    endfunction

    // Wait (bounded) for done; returns number of rising edges observed.
    task automatic wait_done(output int n);
        bit seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            @(posedge clock);
            n++;
            @(negedge clock);
            seen = done;
        end
    endtask

    // Full operation: start for one cycle, check busy, latency, result, done width.
    task automatic run_op(input int ta, input int tb_, input string tag);
        int n;
        int exp;
        exp = ref_product(ta, tb_);
        @(negedge clock);
        a = ta[W-1:0];
        b = tb_[W-1:0];
        start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        check_eq({tag, "_busy"}, int'(busy), 1);
        wait_done(n);
        check_eq({tag, "_latency"}, n, 5);
        check_eq({tag, "_result"}, result_s(), exp);
        @(posedge clock);
        @(negedge clock);
        check_eq({tag, "_done_width"}, int'(done), 0);
        check_eq({tag, "_busy_end"}, int'(busy), 0);
        repeat (2) @(negedge clock);
        check_eq({tag, "_hold"}, result_s(), exp);
    endtask

    // Count done pulses over a number of cycles.
    task automatic count_done(input int cycles, output int pulses);
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clock);
            if (done) pulses++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        int n;
        int pulses;
        int ta;
        int tb_;
        int done_at[$];
        reset = 1'b1;
        start = 1'b0;
        a = 4'd0;
        b = 4'd0;

        // Reset with the clock running.
        repeat (3) @(negedge clock);
        check_eq("rst_result", result_s(), 0);
        check_eq("rst_done", int'(done), 0);
        check_eq("rst_busy", int'(busy), 0);
        reset = 1'b0;
        repeat (5) @(negedge clock);
        check_eq("idle_result", result_s(), 0);
        check_eq("idle_done", int'(done), 0);
        check_eq("idle_busy", int'(busy), 0);

        // Directed cases: basic, corners, zero/sign.
        run_op(4, 3, "basic");
        run_op(-8, -8, "m8m8");
        run_op(-8, 7, "m8p7");
        run_op(7, 7, "p7p7");
        run_op(5, 0, "b_zero");
        run_op(-3, 2, "m3p2");
        run_op(0, -1, "a_zero");
        run_op(-1, -1, "m1m1");

        // Randomized operands.
        for (int i = 0; i < 20; i++) begin
            ta = int'($urandom_range(0, 15)) - 8;
            tb_ = int'($urandom_range(0, 15)) - 8;
            run_op(ta, tb_, $sformatf("rand%0d", i));
        end

        // Start and operand change during CALC must be ignored.
        @(negedge clock);
        a = 4'd2;
        b = 4'd3;
        start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        @(posedge clock);
        @(negedge clock);
        start = 1'b1;
        a = 4'd7;
        @(negedge clock);
        start = 1'b0;
        n = 0;
        while (!done && n < 20) begin
            @(negedge clock);
            n++;
        end
        check_eq("ignore_result", result_s(), 6);
        count_done(12, pulses);
        check_eq("ignore_no_second", pulses, 0);
        check_eq("ignore_idle_busy", int'(busy), 0);

        // start held high: back-to-back operations; period is one IDLE cycle,
        // LOAD, WIDTH CALC cycles and DONE.
        @(negedge clock);
        a = 4'hB;  // -5
        b = 4'd6;
        start = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clock);
            if (done) begin
                done_at.push_back(c);
                check_eq("b2b_result", result_s(), -30);
            end
        end
        start = 1'b0;
        check_eq("b2b_pulses_ge3", int'(done_at.size() >= 3), 1);
        if (done_at.size() >= 3) begin
            check_eq("b2b_period0", done_at[1] - done_at[0], W + 3);
            check_eq("b2b_period1", done_at[2] - done_at[1], W + 3);
        end
        repeat (10) @(negedge clock);

        // Asynchronous reset in the middle of CALC.
        @(negedge clock);
        a = 4'd5;
        b = 4'd5;
        start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        check_eq("midrst_result", result_s(), 0);
        check_eq("midrst_busy", int'(busy), 0);
        check_eq("midrst_done", int'(done), 0);
        @(negedge clock);
        reset = 1'b0;
        count_done(12, pulses);
        check_eq("midrst_no_done", pulses, 0);
        check_eq("midrst_hold", result_s(), 0);
        run_op(4, 3, "after_rst");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
